// File: rtl/instr_stream_encoder.sv
// -----------------------------------------------------------------------------
// instr_stream_encoder
//
// Purpose:
//   Turns symbolic instruction requests (mnemonic code plus operand fields) into
//   MIPS-I 32-bit instruction words. The words are queued in a small FIFO and
//   written in order into instruction memory through a word-addressed write
//   port that supports backpressure. Typical uses are as a program loader or a
//   self-test generator placed ahead of the single-cycle CPU.
//
// Handshakes (both ports share the same valid/ready rule):
//   A transfer happens on a rising clk edge where the valid side (in_valid or
//   im_we) and the ready side (in_ready or im_ready) are both high. The valid
//   side holds its payload stable until that transfer happens. in_ready does
//   not depend on in_valid, and im_we does not depend on im_ready.
//
// Ports:
//   clk        in   1     single clock, rising edge
//   rstn       in   1     asynchronous active-low reset
//   start      in   1     one-cycle pulse: flush FIFO, reload address, clear err
//   in_valid   in   1     request valid
//   in_ready   out  1     request accepted on in_valid & in_ready at an edge
//   in_op      in   6     mnemonic code (0..34 legal, 35..63 illegal)
//   in_rs      in   5     rs field
//   in_rt      in   5     rt field
//   in_rd      in   5     rd field
//   in_shamt   in   5     shift amount
//   in_imm     in   16    immediate / branch offset
//   in_target  in   26    jump target field
//   im_we      out  1     memory write request (FIFO not empty)
//   im_ready   in   1     memory accepts the current write
//   im_addr    out  AW    word address of the current write
//   im_wdata   out  32    instruction word of the current write
//   err        out  1     sticky: an illegal in_op was accepted
//   wr_count   out  AW+1  words written since reset/start, saturating
// -----------------------------------------------------------------------------
module instr_stream_encoder #(
  parameter int DEPTH     = 4,
  parameter int AW        = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    in_op,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  output logic          im_we,
  input  logic          im_ready,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          err,
  output logic [AW:0]   wr_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [AW-1:0] LP_BASE = AW'(BASE_ADDR);

  // Mnemonic codes
  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_ADDU = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_SUBU = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd4;
  localparam logic [5:0] OP_OR   = 6'd5;
  localparam logic [5:0] OP_XOR  = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_SLT  = 6'd8;
  localparam logic [5:0] OP_SLTU = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRL  = 6'd11;
  localparam logic [5:0] OP_SRA  = 6'd12;
  localparam logic [5:0] OP_SLLV = 6'd13;
  localparam logic [5:0] OP_SRLV = 6'd14;
  localparam logic [5:0] OP_SRAV = 6'd15;
  localparam logic [5:0] OP_JR   = 6'd16;
  localparam logic [5:0] OP_JALR = 6'd17;
  localparam logic [5:0] OP_ADDI = 6'd18;
  localparam logic [5:0] OP_ANDI = 6'd19;
  localparam logic [5:0] OP_ORI  = 6'd20;
  localparam logic [5:0] OP_SLTI = 6'd21;
  localparam logic [5:0] OP_LUI  = 6'd22;
  localparam logic [5:0] OP_LW   = 6'd23;
  localparam logic [5:0] OP_LB   = 6'd24;
  localparam logic [5:0] OP_LH   = 6'd25;
  localparam logic [5:0] OP_LBU  = 6'd26;
  localparam logic [5:0] OP_LHU  = 6'd27;
  localparam logic [5:0] OP_SW   = 6'd28;
  localparam logic [5:0] OP_SB   = 6'd29;
  localparam logic [5:0] OP_SH   = 6'd30;
  localparam logic [5:0] OP_BEQ  = 6'd31;
  localparam logic [5:0] OP_BNE  = 6'd32;
  localparam logic [5:0] OP_J    = 6'd33;
  localparam logic [5:0] OP_JAL  = 6'd34;

  // Instruction classes
  localparam logic [1:0] CL_R = 2'd0;
  localparam logic [1:0] CL_I = 2'd1;
  localparam logic [1:0] CL_J = 2'd2;

  // ---------------------------------------------------------------------------
  // Combinational encoder
  // ---------------------------------------------------------------------------
  logic        w_legal;
  logic [1:0]  w_class;
  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic        w_is_shift;
  logic        w_is_jr;
  logic        w_is_jalr;
  logic        w_is_lui;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [31:0] w_word;

  always_comb begin
    w_legal  = 1'b1;
    w_class  = CL_R;
    w_opcode = 6'h00;
    w_funct  = 6'h00;
    unique case (in_op)
      OP_ADD:  w_funct = 6'h20;
      OP_ADDU: w_funct = 6'h21;
      OP_SUB:  w_funct = 6'h22;
      OP_SUBU: w_funct = 6'h23;
      OP_AND:  w_funct = 6'h24;
      OP_OR:   w_funct = 6'h25;
      OP_XOR:  w_funct = 6'h26;
      OP_NOR:  w_funct = 6'h27;
      OP_SLT:  w_funct = 6'h2a;
      OP_SLTU: w_funct = 6'h2b;
      OP_SLL:  w_funct = 6'h00;
      OP_SRL:  w_funct = 6'h02;
      OP_SRA:  w_funct = 6'h03;
      OP_SLLV: w_funct = 6'h04;
      OP_SRLV: w_funct = 6'h06;
      OP_SRAV: w_funct = 6'h07;
      OP_JR:   w_funct = 6'h08;
      OP_JALR: w_funct = 6'h09;
      OP_ADDI: begin w_class = CL_I; w_opcode = 6'h08; end
      OP_ANDI: begin w_class = CL_I; w_opcode = 6'h0c; end
      OP_ORI:  begin w_class = CL_I; w_opcode = 6'h0d; end
      OP_SLTI: begin w_class = CL_I; w_opcode = 6'h0a; end
      OP_LUI:  begin w_class = CL_I; w_opcode = 6'h0f; end
      OP_LW:   begin w_class = CL_I; w_opcode = 6'h23; end
      OP_LB:   begin w_class = CL_I; w_opcode = 6'h20; end
      OP_LH:   begin w_class = CL_I; w_opcode = 6'h21; end
      OP_LBU:  begin w_class = CL_I; w_opcode = 6'h24; end
      OP_LHU:  begin w_class = CL_I; w_opcode = 6'h25; end
      OP_SW:   begin w_class = CL_I; w_opcode = 6'h2b; end
      OP_SB:   begin w_class = CL_I; w_opcode = 6'h28; end
      OP_SH:   begin w_class = CL_I; w_opcode = 6'h29; end
      OP_BEQ:  begin w_class = CL_I; w_opcode = 6'h04; end
      OP_BNE:  begin w_class = CL_I; w_opcode = 6'h05; end
      OP_J:    begin w_class = CL_J; w_opcode = 6'h02; end
      OP_JAL:  begin w_class = CL_J; w_opcode = 6'h03; end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_is_shift = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);
  assign w_is_jr    = (in_op == OP_JR);
  assign w_is_jalr  = (in_op == OP_JALR);
  assign w_is_lui   = (in_op == OP_LUI);

  // Field forcing: immediate shifts carry no rs; only immediate shifts carry a
  // shamt; jr uses rs alone; jalr uses rs and rd.
  assign w_rs    = (w_is_shift || (w_class == CL_I && w_is_lui)) ? 5'd0 : in_rs;
  assign w_rt    = (w_is_jr || w_is_jalr) ? 5'd0 : in_rt;
  assign w_rd    = w_is_jr ? 5'd0 : in_rd;
  assign w_shamt = w_is_shift ? in_shamt : 5'd0;

  always_comb begin
    w_word = 32'h0;
    case (w_class)
      CL_R:    w_word = {6'h00, w_rs, w_rt, w_rd, w_shamt, w_funct};
      CL_I:    w_word = {w_opcode, w_rs, in_rt, in_imm};
      CL_J:    w_word = {w_opcode, in_target};
      default: w_word = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO: pointers carry one extra wrap bit so full and empty are distinct.
  // ---------------------------------------------------------------------------
  logic [31:0]   r_mem [DEPTH];
  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_count;
  logic          r_err;

  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) &&
                   (r_wptr[PW-1:0] == r_rptr[PW-1:0]);

  // No bypass when full: a pop in the same cycle does not open a slot early.
  assign in_ready = rstn & ~w_full & ~start;
  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & w_legal;
  assign w_pop    = ~w_empty & im_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_addr  <= LP_BASE;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (start) begin
      // A push or pop coinciding with start is dropped.
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_addr  <= LP_BASE;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[PW-1:0]] <= w_word;
        r_wptr                <= r_wptr + (PW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (PW+1)'(1);
        r_addr <= r_addr + AW'(1);
        if (r_count != '1) begin
          r_count <= r_count + (AW+1)'(1);
        end
      end
      if (w_accept && !w_legal) begin
        r_err <= 1'b1;
      end
    end
  end

  assign im_we    = ~w_empty;
  assign im_addr  = r_addr;
  // Drive zero while idle so the bus does not show a stale word.
  assign im_wdata = w_empty ? 32'h0 : r_mem[r_rptr[PW-1:0]];
  assign err      = r_err;
  assign wr_count = r_count;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_stream_encoder
//
// Purpose:
//   Bench for instr_stream_encoder. Two instances share one stimulus stream:
//   dut uses the default parameters, dut2 uses AW=2 / BASE_ADDR=3 to exercise
//   address wrap and count saturation. A reference model (expected queue of
//   instruction words built from opcode/funct tables) predicts every output at
//   each falling edge.
// -----------------------------------------------------------------------------
module tb_instr_stream_encoder;

  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stimulus
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  in_op = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        im_ready = 1'b0;

  // dut outputs
  logic        in_ready, im_we, err;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic [10:0] wr_count;

  // dut2 outputs
  logic        in_ready2, im_we2, err2;
  logic [1:0]  im_addr2;
  logic [31:0] im_wdata2;
  logic [2:0]  wr_count2;

  instr_stream_encoder #(.DEPTH(DEPTH), .AW(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target),
    .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr),
    .im_wdata(im_wdata), .err(err), .wr_count(wr_count)
  );

  instr_stream_encoder #(.DEPTH(DEPTH), .AW(2), .BASE_ADDR(3)) dut2 (
    .clk(clk), .rstn(rstn), .start(start),
    .in_valid(in_valid), .in_ready(in_ready2), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target),
    .im_we(im_we2), .im_ready(im_ready), .im_addr(im_addr2),
    .im_wdata(im_wdata2), .err(err2), .wr_count(wr_count2)
  );

  // counters
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference tables
  logic [5:0] funct_tab [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02,
                                 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09};
  logic [5:0] opc_tab [15]   = '{6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h0f, 6'h23,
                                 6'h20, 6'h21, 6'h24, 6'h25, 6'h2b, 6'h28,
                                 6'h29, 6'h04, 6'h05};

  function automatic logic [31:0] ref_encode(input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
      input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tgt);
    int k;
    logic [4:0] s, t, d, a;
    k = int'(op);
    if (k <= 17) begin
      s = rs; t = rt; d = rd; a = 5'd0;
      if (k >= 10 && k <= 12) begin s = 5'd0; a = sh; end
      if (k == 16) begin t = 5'd0; d = 5'd0; end
      if (k == 17) t = 5'd0;
      return {6'h00, s, t, d, a, funct_tab[k]};
    end else if (k <= 32) begin
      return {opc_tab[k-18], (k == 22) ? 5'd0 : rs, rt, imm};
    end
    return {(k == 33) ? 6'h02 : 6'h03, tgt};
  endfunction

  // scoreboard / model
  logic [31:0] exp_q[$];
  logic [9:0]  m_addr  = 10'd0;
  logic [1:0]  m_addr2 = 2'd3;
  logic [10:0] m_cnt   = '0;
  logic [2:0]  m_cnt2  = '0;
  logic        m_err   = 1'b0;

  logic [9:0]  log_addr[$];
  logic [1:0]  log_addr2[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];

  always @(negedge clk) begin
    logic m_ready, m_we;
    if (!rstn) begin
      exp_q.delete();
      m_addr = 10'd0; m_addr2 = 2'd3; m_cnt = '0; m_cnt2 = '0; m_err = 1'b0;
      check("rst_in_ready", in_ready, 0);
      check("rst_im_we", im_we, 0);
      check("rst_im_addr", im_addr, 0);
      check("rst_im_wdata", im_wdata, 0);
      check("rst_err", err, 0);
      check("rst_wr_count", wr_count, 0);
      check("rst_im_addr2", im_addr2, 3);
    end else begin
      m_ready = (exp_q.size() < DEPTH) && !start;
      m_we    = (exp_q.size() != 0);
      check("in_ready", in_ready, m_ready);
      check("im_we", im_we, m_we);
      check("im_addr", im_addr, m_addr);
      check("err", err, m_err);
      check("wr_count", wr_count, m_cnt);
      check("in_ready2", in_ready2, m_ready);
      check("im_we2", im_we2, m_we);
      check("im_addr2", im_addr2, m_addr2);
      check("err2", err2, m_err);
      check("wr_count2", wr_count2, m_cnt2);
      if (m_we) begin
        check("im_wdata", im_wdata, exp_q[0]);
        check("im_wdata2", im_wdata2, exp_q[0]);
      end
      if (start) begin
        exp_q.delete();
        m_addr = 10'd0; m_addr2 = 2'd3; m_cnt = '0; m_cnt2 = '0; m_err = 1'b0;
      end else begin
        if (m_we && im_ready) begin
          log_addr.push_back(im_addr);
          log_addr2.push_back(im_addr2);
          log_data.push_back(im_wdata);
          log_cyc.push_back(cyc);
          void'(exp_q.pop_front());
          m_addr  = m_addr + 10'd1;
          m_addr2 = m_addr2 + 2'd1;
          if (m_cnt != 11'h7ff) m_cnt = m_cnt + 11'd1;
          if (m_cnt2 != 3'h7) m_cnt2 = m_cnt2 + 3'd1;
        end
        if (in_valid && m_ready) begin
          if (in_op <= 6'd34)
            exp_q.push_back(ref_encode(in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target));
          else
            m_err = 1'b1;
        end
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_req(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [25:0] tgt);
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt;
  endtask

  task automatic wait_accept(input string tag);
    bit done = 1'b0;
    for (int b = 0; b < 50 && !done; b++) begin
      @(negedge clk);
      if (in_ready) begin @(posedge clk); #1; done = 1'b1; end
    end
    in_valid = 1'b0;
    check({tag, "_accepted"}, done, 1);
  endtask

  task automatic push(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh,
                      input logic [15:0] imm, input logic [25:0] tgt);
    set_req(op, rs, rt, rd, sh, imm, tgt);
    wait_accept("push");
  endtask

  task automatic push_rand_legal(output logic [31:0] word);
    logic [5:0] op;
    logic [4:0] rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    op = 6'($urandom_range(0, 34));
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
    imm = 16'($urandom); tgt = 26'($urandom);
    word = ref_encode(op, rs, rt, rd, sh, imm, tgt);
    push(op, rs, rt, rd, sh, imm, tgt);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit ok = 1'b0;
    for (int b = 0; b < 200 && !ok; b++) begin
      step(1);
      if (exp_q.size() == 0) ok = 1'b1;
    end
    check({tag, "_drained"}, ok, 1);
  endtask

  task automatic clear_log();
    log_addr.delete(); log_addr2.delete(); log_data.delete(); log_cyc.delete();
  endtask

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // directed and random sequence
  initial begin
    logic [31:0] words [5];
    logic [31:0] w;
    step(3);
    rstn = 1'b1;
    step(1);

    // addu, single word, latency
    im_ready = 1'b1;
    clear_log();
    push(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    check("t1_im_we_next_cycle", im_we, 1);
    drain("t1");
    check("t1_log_size", log_data.size(), 1);
    check("t1_addr", log_addr[0], 0);
    check("t1_data", log_data[0], 32'h00221821);
    check("t1_wr_count", wr_count, 1);

    // sll / lw / j back-to-back
    pulse_start();
    clear_log();
    push(6'd10, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0);
    push(6'd23, 5'd1, 5'd2, 5'd0, 5'd0, 16'h4, 26'h0);
    push(6'd33, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100000);
    drain("t2");
    check("t2_log_size", log_data.size(), 3);
    check("t2_data0", log_data[0], 32'h00011100);
    check("t2_data1", log_data[1], 32'h8C220004);
    check("t2_data2", log_data[2], 32'h08100000);
    check("t2_addr0", log_addr[0], 0);
    check("t2_addr1", log_addr[1], 1);
    check("t2_addr2", log_addr[2], 2);

    // backpressure: fill FIFO, fifth blocked, then burst out
    pulse_start();
    clear_log();
    im_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_rand_legal(words[i]);
    set_req(6'd20, 5'd3, 5'd4, 5'd0, 5'd0, 16'hbeef, 26'h0);
    words[4] = ref_encode(6'd20, 5'd3, 5'd4, 5'd0, 5'd0, 16'hbeef, 26'h0);
    for (int i = 0; i < 3; i++) begin
      check("t3_in_ready_full", in_ready, 0);
      check("t3_hold_addr", im_addr, 0);
      check("t3_hold_data", im_wdata, words[0]);
      step(1);
    end
    im_ready = 1'b1;
    wait_accept("t3_fifth");
    drain("t3");
    check("t3_log_size", log_data.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("t3_order", log_data[i], words[i]);
      check("t3_addr", log_addr[i], i);
    end
    for (int i = 0; i < 3; i++) check("t3_consecutive", log_cyc[i+1] - log_cyc[i], 1);

    // illegal op then addi
    pulse_start();
    clear_log();
    push(6'd40, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    push(6'd18, 5'd0, 5'd1, 5'd0, 5'd0, 16'h5, 26'h0);
    drain("t4");
    check("t4_err_set", err, 1);
    check("t4_log_size", log_data.size(), 1);
    check("t4_data", log_data[0], 32'h20010005);
    check("t4_addr", log_addr[0], 0);
    pulse_start();
    check("t4_err_cleared", err, 0);
    check("t4_count_cleared", wr_count, 0);

    // address wrap on AW=2, BASE_ADDR=3
    clear_log();
    for (int i = 0; i < 5; i++) push_rand_legal(w);
    drain("t5");
    check("t5_log_size", log_addr2.size(), 5);
    check("t5_a0", log_addr2[0], 3);
    check("t5_a1", log_addr2[1], 0);
    check("t5_a2", log_addr2[2], 1);
    check("t5_a3", log_addr2[3], 2);
    check("t5_a4", log_addr2[4], 3);
    check("t5_wr_count2", wr_count2, 5);

    // start with 3 queued and a pending push
    pulse_start();
    clear_log();
    im_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_rand_legal(w);
    set_req(6'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    in_valid = 1'b0;
    im_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t6_no_we", im_we, 0);
      step(1);
    end
    check("t6_no_writes", log_data.size(), 0);
    push(6'd6, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
    drain("t6");
    check("t6_log_size", log_data.size(), 1);
    check("t6_addr", log_addr[0], 0);

    // randomized traffic including illegal ops, starts, and a mid-run reset
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_op     = 6'($urandom_range(0, 40));
      in_rs     = 5'($urandom); in_rt = 5'($urandom);
      in_rd     = 5'($urandom); in_shamt = 5'($urandom);
      in_imm    = 16'($urandom); in_target = 26'($urandom);
      im_ready  = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 79) == 0);
      if (i == 300) rstn = 1'b0;
      if (i == 302) rstn = 1'b1;
      step(1);
    end
    in_valid = 1'b0;
    start = 1'b0;
    im_ready = 1'b1;
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
